// File: rtl/prf_multiport_ready.sv
// -----------------------------------------------------------------------------
// prf_multiport_ready
//
// Physical register file for the out-of-order core. Each physical register
// holds a data word and a ready bit. Dispatch allocation clears the ready bit;
// writeback stores the data and sets the ready bit. Reads are combinational
// and forward same-cycle writebacks. A registered busy counter and ready
// vector feed the issue/dispatch stall logic.
//
// Ports:
//   clk         clock
//   reset       synchronous, active-high reset
//   rd_idx      NUM_RD read indices, port r at [r*IDX_W +: IDX_W]
//   rd_data     NUM_RD read data words (combinational)
//   rd_ready    NUM_RD ready bits (combinational)
//   wr_en       NUM_WR writeback valids
//   wr_idx      NUM_WR writeback indices
//   wr_data     NUM_WR writeback data words
//   alloc_en    NUM_ALLOC allocation valids
//   alloc_idx   NUM_ALLOC allocated preg indices
//   busy_count  registered number of not-ready registers (0..PREG_NUMBER)
//   ready_vec   registered ready bits
// -----------------------------------------------------------------------------
module prf_multiport_ready #(
    parameter int PREG_NUMBER = 64,
    parameter int XLEN        = 64,
    parameter int NUM_RD      = 4,
    parameter int NUM_WR      = 2,
    parameter int NUM_ALLOC   = 2,
    parameter int ZERO_REG_EN = 1,
    localparam int IDX_W      = $clog2(PREG_NUMBER)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_RD*IDX_W-1:0]     rd_idx,
    output logic [NUM_RD*XLEN-1:0]      rd_data,
    output logic [NUM_RD-1:0]           rd_ready,
    input  logic [NUM_WR-1:0]           wr_en,
    input  logic [NUM_WR*IDX_W-1:0]     wr_idx,
    input  logic [NUM_WR*XLEN-1:0]      wr_data,
    input  logic [NUM_ALLOC-1:0]        alloc_en,
    input  logic [NUM_ALLOC*IDX_W-1:0]  alloc_idx,
    output logic [IDX_W:0]              busy_count,
    output logic [PREG_NUMBER-1:0]      ready_vec
);

    localparam bit ZERO_EN = (ZERO_REG_EN != 0);

    logic [XLEN-1:0]        storage [PREG_NUMBER];
    logic [PREG_NUMBER-1:0] ready_q;
    logic [PREG_NUMBER-1:0] next_ready;
    logic [IDX_W:0]         busy_q;

    // True when idx addresses the hardwired zero register.
    function automatic logic is_zero(input logic [IDX_W-1:0] idx);
        return ZERO_EN && (idx == '0);
    endfunction

    function automatic logic [IDX_W:0] count_zeros(input logic [PREG_NUMBER-1:0] v);
        logic [IDX_W:0] n;
        n = '0;
        for (int i = 0; i < PREG_NUMBER; i++) begin
            n = n + {{IDX_W{1'b0}}, ~v[i]};
        end
        return n;
    endfunction

    // Next ready state: writebacks set, then allocations clear, so an alloc
    // and a write to the same preg in one cycle leave it not ready.
    always_comb begin
        next_ready = ready_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && !is_zero(wr_idx[w*IDX_W +: IDX_W])) begin
                next_ready[wr_idx[w*IDX_W +: IDX_W]] = 1'b1;
            end
        end
        for (int a = 0; a < NUM_ALLOC; a++) begin
            if (alloc_en[a] && !is_zero(alloc_idx[a*IDX_W +: IDX_W])) begin
                next_ready[alloc_idx[a*IDX_W +: IDX_W]] = 1'b0;
            end
        end
    end

    // NOTE: the data array is reset as a whole because reads of unwritten
    // pregs must return 0; this keeps it out of dense RAM macros.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PREG_NUMBER; i++) begin
                storage[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking writes in ascending port order make the
            // highest-numbered port win on an index collision, matching the
            // forwarding priority in the read path below.
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && !is_zero(wr_idx[w*IDX_W +: IDX_W])) begin
                    storage[wr_idx[w*IDX_W +: IDX_W]] <= wr_data[w*XLEN +: XLEN];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q <= '1;
            busy_q  <= '0;
        end else begin
            ready_q <= next_ready;
            busy_q  <= count_zeros(next_ready);
        end
    end

    // Read path: storage, overridden by the highest-numbered matching write,
    // overridden in turn by the zero register.
    // NOTE: every output gets a default before the loops so no latch is
    // inferred for any slice.
    always_comb begin
        rd_data  = '0;
        rd_ready = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            rd_data[r*XLEN +: XLEN] = storage[rd_idx[r*IDX_W +: IDX_W]];
            rd_ready[r]             = ready_q[rd_idx[r*IDX_W +: IDX_W]];
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && (wr_idx[w*IDX_W +: IDX_W] == rd_idx[r*IDX_W +: IDX_W])) begin
                    rd_data[r*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
                    rd_ready[r]             = 1'b1;
                end
            end
            if (is_zero(rd_idx[r*IDX_W +: IDX_W])) begin
                rd_data[r*XLEN +: XLEN] = '0;
                rd_ready[r]             = 1'b1;
            end
        end
    end

    assign busy_count = busy_q;
    assign ready_vec  = ready_q;

endmodule

// File: tb/tb_prf_multiport_ready.sv
// -----------------------------------------------------------------------------
// tb_prf_multiport_ready
//
// Self-checking bench for prf_multiport_ready with default parameters.
// Directed table of vectors with hand-derived expectations, hand-written
// full-allocation / reset sequence, then randomized traffic checked against
// an array-based reference model of the register file.
// -----------------------------------------------------------------------------
module tb_prf_multiport_ready;

    localparam int P  = 64;
    localparam int X  = 64;
    localparam int NR = 4;
    localparam int NW = 2;
    localparam int NA = 2;
    localparam int IW = 6;

    logic               clk = 1'b0;
    logic               reset;
    logic [NR*IW-1:0]   rd_idx;
    logic [NR*X-1:0]    rd_data;
    logic [NR-1:0]      rd_ready;
    logic [NW-1:0]      wr_en;
    logic [NW*IW-1:0]   wr_idx;
    logic [NW*X-1:0]    wr_data;
    logic [NA-1:0]      alloc_en;
    logic [NA*IW-1:0]   alloc_idx;
    logic [IW:0]        busy_count;
    logic [P-1:0]       ready_vec;

    always #5 clk = ~clk;

    prf_multiport_ready #(
        .PREG_NUMBER(P), .XLEN(X), .NUM_RD(NR), .NUM_WR(NW),
        .NUM_ALLOC(NA), .ZERO_REG_EN(1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .rd_ready   (rd_ready),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .alloc_en   (alloc_en),
        .alloc_idx  (alloc_idx),
        .busy_count (busy_count),
        .ready_vec  (ready_vec)
    );

    // Unpacked stimulus variables, packed onto the DUT ports.
    logic           drv_rst;
    logic [NW-1:0]  drv_we;
    logic [IW-1:0]  drv_wi [NW];
    logic [X-1:0]   drv_wd [NW];
    logic [NA-1:0]  drv_ae;
    logic [IW-1:0]  drv_ai [NA];
    logic [IW-1:0]  drv_ri [NR];

    always_comb begin
        reset    = drv_rst;
        wr_en    = drv_we;
        alloc_en = drv_ae;
        for (int w = 0; w < NW; w++) begin
            wr_idx[w*IW +: IW] = drv_wi[w];
            wr_data[w*X +: X]  = drv_wd[w];
        end
        for (int a = 0; a < NA; a++) alloc_idx[a*IW +: IW] = drv_ai[a];
        for (int r = 0; r < NR; r++) rd_idx[r*IW +: IW] = drv_ri[r];
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [X-1:0] act, input logic [X-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain arrays holding what each preg contains.
    logic [X-1:0] m_data [P];
    logic [P-1:0] m_rdy;

    task automatic model_edge();
        if (drv_rst) begin
            for (int i = 0; i < P; i++) m_data[i] = '0;
            m_rdy = '1;
        end else begin
            for (int w = 0; w < NW; w++) begin
                if (drv_we[w] && drv_wi[w] != 0) begin
                    m_data[drv_wi[w]] = drv_wd[w];
                    m_rdy[drv_wi[w]]  = 1'b1;
                end
            end
            for (int a = 0; a < NA; a++) begin
                if (drv_ae[a] && drv_ai[a] != 0) m_rdy[drv_ai[a]] = 1'b0;
            end
        end
    endtask

    // Expected read: zero reg, else newest (highest-port) in-flight write,
    // else stored state.
    task automatic exp_read(input logic [IW-1:0] idx, output logic [X-1:0] d, output logic rdy);
        bit found;
        found = 0;
        d     = m_data[idx];
        rdy   = m_rdy[idx];
        for (int w = NW - 1; w >= 0; w--) begin
            if (!found && drv_we[w] && drv_wi[w] == idx) begin
                d     = drv_wd[w];
                rdy   = 1'b1;
                found = 1;
            end
        end
        if (idx == 0) begin
            d   = '0;
            rdy = 1'b1;
        end
    endtask

    task automatic check_reads_model(input string tag);
        logic [X-1:0] d;
        logic         rdy;
        for (int r = 0; r < NR; r++) begin
            exp_read(drv_ri[r], d, rdy);
            check($sformatf("%s_rd%0d_data", tag, r), rd_data[r*X +: X], d);
            check($sformatf("%s_rd%0d_rdy", tag, r), {63'b0, rd_ready[r]}, {63'b0, rdy});
        end
    endtask

    task automatic check_regs_model(input string tag);
        int zeros;
        zeros = 0;
        for (int i = 0; i < P; i++) if (!m_rdy[i]) zeros++;
        check({tag, "_busy"}, {57'b0, busy_count}, X'(zeros));
        check({tag, "_ready_vec"}, ready_vec, m_rdy);
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        drv_rst = 1'b0;
        drv_we  = '0;
        drv_ae  = '0;
        for (int w = 0; w < NW; w++) begin
            drv_wi[w] = '0;
            drv_wd[w] = '0;
        end
        for (int a = 0; a < NA; a++) drv_ai[a] = '0;
        for (int r = 0; r < NR; r++) drv_ri[r] = '0;
    endtask

    typedef struct {
        logic         rst;
        logic [1:0]   we;
        logic [IW-1:0] wi0, wi1;
        logic [X-1:0] wd0, wd1;
        logic [1:0]   ae;
        logic [IW-1:0] ai0, ai1;
        logic [IW-1:0] ri0, ri1;
        logic [X-1:0] ed0;
        logic         er0;
        logic [X-1:0] ed1;
        logic         er1;
        int           eb;
    } vec_t;

    vec_t tbl [13];

    initial begin
        // rst we wi0 wi1 wd0 wd1 ae ai0 ai1 ri0 ri1 | ed0 er0 ed1 er1 busy_after
        tbl[0]  = '{1'b1, 2'b00, 6'd0, 6'd0, 64'h0,  64'h0,  2'b00, 6'd0,  6'd0,  6'd0,  6'd1, 64'h0,    1'b1, 64'h0,    1'b1, 0};
        tbl[1]  = '{1'b0, 2'b00, 6'd0, 6'd0, 64'h0,  64'h0,  2'b01, 6'd5,  6'd0,  6'd5,  6'd3, 64'h0,    1'b1, 64'h0,    1'b1, 1};
        tbl[2]  = '{1'b0, 2'b00, 6'd0, 6'd0, 64'h0,  64'h0,  2'b00, 6'd0,  6'd0,  6'd5,  6'd0, 64'h0,    1'b0, 64'h0,    1'b1, 1};
        tbl[3]  = '{1'b0, 2'b10, 6'd0, 6'd5, 64'h0,  64'hDEAD, 2'b00, 6'd0, 6'd0, 6'd5,  6'd5, 64'hDEAD, 1'b1, 64'hDEAD, 1'b1, 0};
        tbl[4]  = '{1'b0, 2'b00, 6'd0, 6'd0, 64'h0,  64'h0,  2'b00, 6'd0,  6'd0,  6'd5,  6'd9, 64'hDEAD, 1'b1, 64'h0,    1'b1, 0};
        tbl[5]  = '{1'b0, 2'b11, 6'd9, 6'd9, 64'h11, 64'h22, 2'b00, 6'd0,  6'd0,  6'd9,  6'd5, 64'h22,   1'b1, 64'hDEAD, 1'b1, 0};
        tbl[6]  = '{1'b0, 2'b00, 6'd0, 6'd0, 64'h0,  64'h0,  2'b00, 6'd0,  6'd0,  6'd9,  6'd7, 64'h22,   1'b1, 64'h0,    1'b1, 0};
        tbl[7]  = '{1'b0, 2'b01, 6'd7, 6'd0, 64'h33, 64'h0,  2'b01, 6'd7,  6'd0,  6'd7,  6'd9, 64'h33,   1'b1, 64'h22,   1'b1, 1};
        tbl[8]  = '{1'b0, 2'b00, 6'd0, 6'd0, 64'h0,  64'h0,  2'b00, 6'd0,  6'd0,  6'd7,  6'd0, 64'h33,   1'b0, 64'h0,    1'b1, 1};
        tbl[9]  = '{1'b0, 2'b01, 6'd0, 6'd0, 64'hFF, 64'h0,  2'b10, 6'd0,  6'd0,  6'd0,  6'd7, 64'h0,    1'b1, 64'h33,   1'b0, 1};
        tbl[10] = '{1'b0, 2'b00, 6'd0, 6'd0, 64'h0,  64'h0,  2'b00, 6'd0,  6'd0,  6'd0,  6'd0, 64'h0,    1'b1, 64'h0,    1'b1, 1};
        tbl[11] = '{1'b0, 2'b00, 6'd0, 6'd0, 64'h0,  64'h0,  2'b11, 6'd12, 6'd12, 6'd12, 6'd7, 64'h0,    1'b1, 64'h33,   1'b0, 2};
        tbl[12] = '{1'b0, 2'b00, 6'd0, 6'd0, 64'h0,  64'h0,  2'b00, 6'd0,  6'd0,  6'd12, 6'd5, 64'h0,    1'b0, 64'hDEAD, 1'b1, 2};

        // Bring storage to a known state before the table.
        idle();
        drv_rst = 1'b1;
        edge_step();

        // ---------------- table-driven directed vectors ----------------
        for (int i = 0; i < 13; i++) begin
            drv_rst   = tbl[i].rst;
            drv_we    = tbl[i].we;
            drv_wi[0] = tbl[i].wi0;
            drv_wi[1] = tbl[i].wi1;
            drv_wd[0] = tbl[i].wd0;
            drv_wd[1] = tbl[i].wd1;
            drv_ae    = tbl[i].ae;
            drv_ai[0] = tbl[i].ai0;
            drv_ai[1] = tbl[i].ai1;
            drv_ri[0] = tbl[i].ri0;
            drv_ri[1] = tbl[i].ri1;
            drv_ri[2] = tbl[i].ri1;
            drv_ri[3] = tbl[i].ri0;
            #2;
            check($sformatf("vec%0d_rd0_data", i), rd_data[0*X +: X], tbl[i].ed0);
            check($sformatf("vec%0d_rd0_rdy", i), {63'b0, rd_ready[0]}, {63'b0, tbl[i].er0});
            check($sformatf("vec%0d_rd1_data", i), rd_data[1*X +: X], tbl[i].ed1);
            check($sformatf("vec%0d_rd1_rdy", i), {63'b0, rd_ready[1]}, {63'b0, tbl[i].er1});
            check($sformatf("vec%0d_rd2_data", i), rd_data[2*X +: X], tbl[i].ed1);
            check($sformatf("vec%0d_rd2_rdy", i), {63'b0, rd_ready[2]}, {63'b0, tbl[i].er1});
            check($sformatf("vec%0d_rd3_data", i), rd_data[3*X +: X], tbl[i].ed0);
            check($sformatf("vec%0d_rd3_rdy", i), {63'b0, rd_ready[3]}, {63'b0, tbl[i].er0});
            edge_step();
            check($sformatf("vec%0d_busy", i), {57'b0, busy_count}, X'(tbl[i].eb));
            check($sformatf("vec%0d_ready_vec", i), ready_vec, m_rdy);
        end

        // ---------------- allocate every nonzero preg ----------------
        idle();
        drv_rst = 1'b1;
        edge_step();
        check("full_reset_busy", {57'b0, busy_count}, 64'd0);
        for (int i = 1; i < P; i++) begin
            idle();
            drv_ae    = 2'b01;
            drv_ai[0] = IW'(i);
            edge_step();
            check($sformatf("full_alloc%0d_busy", i), {57'b0, busy_count}, X'(i));
        end
        check("full_ready_vec", ready_vec, 64'h1);
        // Re-allocating busy regs and the zero reg must not move the count.
        idle();
        drv_ae    = 2'b11;
        drv_ai[0] = 6'd1;
        drv_ai[1] = 6'd0;
        edge_step();
        check("full_nowrap_busy", {57'b0, busy_count}, 64'd63);

        // Reset with a simultaneous write and alloc: both dropped.
        idle();
        drv_rst   = 1'b1;
        drv_we    = 2'b01;
        drv_wi[0] = 6'd3;
        drv_wd[0] = 64'hAB;
        drv_ae    = 2'b01;
        drv_ai[0] = 6'd4;
        edge_step();
        idle();
        drv_ri[0] = 6'd3;
        drv_ri[1] = 6'd4;
        #2;
        check("rst_busy", {57'b0, busy_count}, 64'd0);
        check("rst_ready_vec", ready_vec, {P{1'b1}});
        check("rst_wr_dropped_data", rd_data[0*X +: X], 64'h0);
        check("rst_wr_dropped_rdy", {63'b0, rd_ready[0]}, 64'd1);
        check("rst_alloc_dropped_rdy", {63'b0, rd_ready[1]}, 64'd1);
        edge_step();

        // ---------------- randomized traffic vs model ----------------
        for (int n = 0; n < 400; n++) begin
            drv_rst = ($urandom_range(0, 49) == 0);
            drv_we  = NW'($urandom);
            drv_ae  = ($urandom_range(0, 2) == 0) ? NA'($urandom) : '0;
            for (int w = 0; w < NW; w++) begin
                drv_wi[w] = IW'($urandom_range(0, 15));
                drv_wd[w] = {$urandom, $urandom};
            end
            for (int a = 0; a < NA; a++) drv_ai[a] = IW'($urandom_range(0, 15));
            for (int r = 0; r < NR; r++) begin
                drv_ri[r] = ($urandom_range(0, 7) == 0) ? IW'($urandom_range(0, P - 1))
                                                         : IW'($urandom_range(0, 15));
            end
            #2;
            check_reads_model($sformatf("rand%0d", n));
            edge_step();
            check_regs_model($sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
